and21nor_pipe: RTL and testbench
================================

# and21nor_pipe

Parametrised, pipelined successor of the single-bit and21nor cell: a WIDTH-lane AND-OR-INVERT / OR-AND-INVERT datapath behind an elastic valid/ready pipeline of DEPTH register stages. Each lane computes nq = ~((i0 & i1) | i2) in AOI mode or nq = ~((i0 | i1) & i2) in OAI mode, with the mode chosen per transaction. It sits in the c4m mcu9t3v3 characterisation and regression harness as a streaming logic-function block between a stimulus source and a result sink, and is clocked from the single cell-library test clock.

## Interface
- WIDTH, 8: number of independent lanes; must be at least 1.
- DEPTH, 2: number of pipeline register stages; allowed range 1..4.
- ck  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers a transaction.
- in_ready  output  1  block accepts a transaction this cycle.
- mode  input  1  0 = AOI21, 1 = OAI21; sampled with the transaction.
- i0, i1, i2  input  WIDTH each  lane operands.
- out_valid  output  1  stage DEPTH-1 holds a result.
- out_ready  input  1  downstream accepts the result.
- nq  output  WIDTH  result of the oldest transaction.
- busy  output  1  at least one stage holds valid data.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

## Operation
- The function is evaluated combinationally from i0, i1, i2 and mode, then captured into stage 0 on acceptance.
- Acceptance occurs when in_valid && in_ready at a rising ck.
- Each stage k holds a valid bit and WIDTH data bits. Stage k advances when it is empty or when stage k+1 advances; the last stage advances when out_ready is high.
- in_ready = !v[0] || advance[0]. The ready chain is combinational, so a full pipe with out_ready = 1 accepts every cycle.
- Bubbles collapse: an empty stage takes data from the stage before it even while later stages are stalled.
- Holding rules:
  - While out_valid && !out_ready, nq and out_valid hold stable.
  - A stalled stage never drops or duplicates data.
- nq equals the last-stage data register. It is not gated by out_valid.
- occupancy is the population count of the stage valid bits, from registered state. busy = (occupancy != 0).
- Reset, including mid-stream:
  - All valid bits clear and all data registers clear, so out_valid = 0, nq = 0, busy = 0, occupancy = 0.
  - in_ready = 1 from the first edge after rst deasserts.
  - In-flight transactions are discarded.
- There is no overflow or underflow path. Inputs are ignored while in_ready = 0, and output data is only meaningful while out_valid = 1.

## Timing
- Latency is DEPTH cycles from acceptance to out_valid when unstalled. A transaction accepted at edge n is visible on nq after edge n+DEPTH-1.
- Throughput is 1 transaction per cycle when sustained with out_ready = 1.
- Critical path is out_ready → ready chain → in_ready, which is DEPTH AND-OR levels. No registered skid stage is used.
- Simultaneous accept and emit on a full pipe: occupancy is unchanged and order is preserved (FIFO).

## Structure
- Shared package and21nor_pkg:
  - typedef enum logic {MODE_AOI=1'b0, MODE_OAI=1'b1} mode_t.
  - Function aoi_eval(i0, i1, i2, mode) returning a WIDTH-wide result, reused by the bench reference model.
  - Localparam DEPTH_MAX = 4.
- One sub-module, and21nor_pipe_stage: a single valid/data register with load/advance control, instantiated DEPTH times through a generate loop.

## Test plan
- **Reset values.** WIDTH=4, DEPTH=2: assert rst mid-stream with 2 stages full → out_valid=0, nq=4'b0000, occupancy=0, busy=0 immediately (asynchronous), and in_ready=1 after release.
- **AOI and OAI directed values.** WIDTH=4, DEPTH=2: i0=4'b1100, i1=4'b1010, i2=4'b0001.
  - mode=0 → nq=4'b0110 two cycles after acceptance.
  - Same operands with mode=1 next cycle → nq=4'b1111 one cycle later.
- **Backpressure.** DEPTH=2, out_ready=0, stream 3 transactions:
  - The first 2 are accepted, then in_ready=0 and occupancy=2.
  - Raising out_ready emits results in order, and the third is accepted in the same cycle as the first is emitted.
- **Bubble collapse.** DEPTH=3, out_ready=0, one transaction accepted → it reaches stage 2 after 3 cycles (out_valid=1). The next transaction fills stage 1 without waiting for out_ready.
- **Sustained throughput.** DEPTH=4, WIDTH=8: 100 random transactions with in_valid=out_ready=1 → 100 results in 103 cycles after the first acceptance, all matching aoi_eval, and in_ready never low.
- **Exhaustive truth table.** WIDTH=1: all 16 combinations of {mode, i0, i1, i2} with random in_valid and out_ready toggling → results match the scoreboard in order, with no loss or duplication.

Source files
------------

// File: rtl/and21nor_pipe_pkg.sv
// Shared types and the lane function for the AOI21/OAI21 streaming pipeline.
package and21nor_pkg;

  typedef enum logic {MODE_AOI = 1'b0, MODE_OAI = 1'b1} mode_t;

  localparam int DEPTH_MAX = 4;

  // Widest lane count the shared evaluator handles; callers zero-extend
  // their operands and truncate the result back to their own width.
  localparam int AOI_W_MAX = 64;

  // Bitwise lane function: AOI21 = ~((a & b) | c), OAI21 = ~((a | b) & c).
  function automatic logic [AOI_W_MAX-1:0] aoi_eval(
    input logic [AOI_W_MAX-1:0] i0,
    input logic [AOI_W_MAX-1:0] i1,
    input logic [AOI_W_MAX-1:0] i2,
    input mode_t                mode
  );
    if (mode == MODE_OAI) return ~((i0 | i1) & i2);
    else                  return ~((i0 & i1) | i2);
  endfunction

endpackage

// File: rtl/and21nor_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus WIDTH data bits that take the
// upstream slot whenever this slot advances.
module and21nor_pipe_stage
  import and21nor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             i_adv,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  // Slot register: on advance take the upstream valid; data only moves when
  // something real arrives, so an emptied slot keeps its last value.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (i_adv) begin
      r_vld <= i_vld;
      if (i_vld) r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/and21nor_pipe.sv
// WIDTH-lane AOI21/OAI21 datapath behind a DEPTH-stage elastic valid/ready
// pipeline with a purely combinational ready chain (no skid register).
module and21nor_pipe
  import and21nor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic [WIDTH-1:0]             i0,
  input  logic [WIDTH-1:0]             i1,
  input  logic [WIDTH-1:0]             i2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             nq,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("and21nor_pipe: DEPTH must be within 1..DEPTH_MAX");
  end
  if (WIDTH < 1 || WIDTH > AOI_W_MAX) begin : g_bad_width
    $error("and21nor_pipe: WIDTH must be within 1..AOI_W_MAX");
  end

  logic [WIDTH-1:0] w_func;
  logic [DEPTH-1:0] w_vld;
  logic [WIDTH-1:0] w_dat [DEPTH];
  // w_adv[k] = stage k advances this cycle; w_adv[DEPTH] is the sink's ready.
  logic [DEPTH:0]   w_adv;
  logic [OCC_W-1:0] w_occ;

  assign w_func = WIDTH'(aoi_eval(AOI_W_MAX'(i0), AOI_W_MAX'(i1),
                                  AOI_W_MAX'(i2), mode_t'(mode)));

  // Ready chain from the sink back to the source: a stage moves if it is
  // empty or if the stage after it moves, which also collapses bubbles.
  always_comb begin
    w_adv        = '0;
    w_adv[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_adv[k] = !w_vld[k] || w_adv[k+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      and21nor_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .ck     (ck),
        .rst    (rst),
        .i_adv  (w_adv[g]),
        .i_vld  (in_valid),
        .i_data (w_func),
        .o_vld  (w_vld[g]),
        .o_data (w_dat[g])
      );
    end else begin : g_body
      and21nor_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .ck     (ck),
        .rst    (rst),
        .i_adv  (w_adv[g]),
        .i_vld  (w_vld[g-1]),
        .i_data (w_dat[g-1]),
        .o_vld  (w_vld[g]),
        .o_data (w_dat[g])
      );
    end
  end

  // Population count of the registered stage valid bits.
  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(w_vld[k]);
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_vld[DEPTH-1];
  assign nq        = w_dat[DEPTH-1];
  assign occupancy = w_occ;
  assign busy      = (w_occ != '0);

endmodule

// File: tb/tb_and21nor_pipe.sv
// Directed bench for and21nor_pipe across four width/depth configurations.
module tb_and21nor_pipe;
  import and21nor_pkg::*;

  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  int n_pass = 0;
  int n_total = 0;

  // A: WIDTH=4 DEPTH=2
  logic A_in_valid = 0, A_in_ready, A_mode = 0, A_out_valid, A_out_ready = 0, A_busy;
  logic [3:0] A_i0 = 0, A_i1 = 0, A_i2 = 0, A_nq;
  logic [1:0] A_occ;
  // B: WIDTH=4 DEPTH=3
  logic B_in_valid = 0, B_in_ready, B_mode = 0, B_out_valid, B_out_ready = 0, B_busy;
  logic [3:0] B_i0 = 0, B_i1 = 0, B_i2 = 0, B_nq;
  logic [1:0] B_occ;
  // C: WIDTH=8 DEPTH=4
  logic C_in_valid = 0, C_in_ready, C_mode = 0, C_out_valid, C_out_ready = 0, C_busy;
  logic [7:0] C_i0 = 0, C_i1 = 0, C_i2 = 0, C_nq;
  logic [2:0] C_occ;
  // D: WIDTH=1 DEPTH=2
  logic D_in_valid = 0, D_in_ready, D_mode = 0, D_out_valid, D_out_ready = 0, D_busy;
  logic [0:0] D_i0 = 0, D_i1 = 0, D_i2 = 0, D_nq;
  logic [1:0] D_occ;

  and21nor_pipe #(.WIDTH(4), .DEPTH(2)) u_a (
    .ck(ck), .rst(rst), .in_valid(A_in_valid), .in_ready(A_in_ready), .mode(A_mode),
    .i0(A_i0), .i1(A_i1), .i2(A_i2), .out_valid(A_out_valid), .out_ready(A_out_ready),
    .nq(A_nq), .busy(A_busy), .occupancy(A_occ));
  and21nor_pipe #(.WIDTH(4), .DEPTH(3)) u_b (
    .ck(ck), .rst(rst), .in_valid(B_in_valid), .in_ready(B_in_ready), .mode(B_mode),
    .i0(B_i0), .i1(B_i1), .i2(B_i2), .out_valid(B_out_valid), .out_ready(B_out_ready),
    .nq(B_nq), .busy(B_busy), .occupancy(B_occ));
  and21nor_pipe #(.WIDTH(8), .DEPTH(4)) u_c (
    .ck(ck), .rst(rst), .in_valid(C_in_valid), .in_ready(C_in_ready), .mode(C_mode),
    .i0(C_i0), .i1(C_i1), .i2(C_i2), .out_valid(C_out_valid), .out_ready(C_out_ready),
    .nq(C_nq), .busy(C_busy), .occupancy(C_occ));
  and21nor_pipe #(.WIDTH(1), .DEPTH(2)) u_d (
    .ck(ck), .rst(rst), .in_valid(D_in_valid), .in_ready(D_in_ready), .mode(D_mode),
    .i0(D_i0), .i1(D_i1), .i2(D_i2), .out_valid(D_out_valid), .out_ready(D_out_ready),
    .nq(D_nq), .busy(D_busy), .occupancy(D_occ));

  task automatic test_reset;
    repeat (2) @(posedge ck);
    #2 rst = 1'b0;
    n_total++; if (A_out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", A_out_valid); else n_pass++;
    n_total++; if (A_nq !== 4'b0000) $display("FAIL rst_nq got=%b exp=0000", A_nq); else n_pass++;
    n_total++; if (A_occ !== 2'd0 || A_busy !== 1'b0) $display("FAIL rst_occ_busy got=%0d/%b exp=0/0", A_occ, A_busy); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (A_in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", A_in_ready); else n_pass++;
    // fill both stages, then reset in the middle of a cycle
    A_out_ready = 0; A_in_valid = 1; A_mode = 0; A_i0 = 4'b1111; A_i1 = 4'b0011; A_i2 = 4'b0000;
    @(posedge ck); #1;
    @(posedge ck); #1;
    A_in_valid = 0;
    n_total++; if (A_occ !== 2'd2 || A_nq !== 4'b1100) $display("FAIL rst_prefill got occ=%0d nq=%b exp occ=2 nq=1100", A_occ, A_nq); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (A_out_valid !== 1'b0 || A_nq !== 4'b0000) $display("FAIL async_rst_out got v=%b nq=%b exp v=0 nq=0000", A_out_valid, A_nq); else n_pass++;
    n_total++; if (A_occ !== 2'd0 || A_busy !== 1'b0) $display("FAIL async_rst_occ got=%0d/%b exp=0/0", A_occ, A_busy); else n_pass++;
    #1 rst = 1'b0;
    @(posedge ck); #1;
    n_total++; if (A_in_ready !== 1'b1 || A_out_valid !== 1'b0) $display("FAIL post_rst got rdy=%b v=%b exp rdy=1 v=0", A_in_ready, A_out_valid); else n_pass++;
  endtask

  task automatic test_aoi_oai;
    @(posedge ck); #1;
    A_out_ready = 1; A_in_valid = 1; A_mode = 0; A_i0 = 4'b1100; A_i1 = 4'b1010; A_i2 = 4'b0001;
    #1;
    n_total++; if (A_in_ready !== 1'b1) $display("FAIL dir_in_ready got=%b exp=1", A_in_ready); else n_pass++;
    @(posedge ck); #1;
    A_mode = 1;
    @(posedge ck); #1;
    A_in_valid = 0;
    n_total++; if (A_out_valid !== 1'b1 || A_nq !== 4'b0110) $display("FAIL aoi_nq got v=%b nq=%b exp v=1 nq=0110", A_out_valid, A_nq); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (A_out_valid !== 1'b1 || A_nq !== 4'b1111) $display("FAIL oai_nq got v=%b nq=%b exp v=1 nq=1111", A_out_valid, A_nq); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (A_out_valid !== 1'b0) $display("FAIL dir_drain got=%b exp=0", A_out_valid); else n_pass++;
  endtask

  task automatic test_backpressure;
    @(posedge ck); #1;
    A_out_ready = 0; A_in_valid = 1;
    A_mode = 0; A_i0 = 4'b1111; A_i1 = 4'b0011; A_i2 = 4'b0000;   // -> 1100
    @(posedge ck); #1;
    A_mode = 1; A_i0 = 4'b0101; A_i1 = 4'b0000; A_i2 = 4'b0110;   // -> 1011
    #1;
    n_total++; if (A_in_ready !== 1'b1) $display("FAIL bp_second_ready got=%b exp=1", A_in_ready); else n_pass++;
    @(posedge ck); #1;
    A_mode = 0; A_i0 = 4'b1010; A_i1 = 4'b1111; A_i2 = 4'b0100;   // -> 0001
    #1;
    n_total++; if (A_in_ready !== 1'b0 || A_occ !== 2'd2) $display("FAIL bp_full got rdy=%b occ=%0d exp rdy=0 occ=2", A_in_ready, A_occ); else n_pass++;
    n_total++; if (A_out_valid !== 1'b1 || A_nq !== 4'b1100) $display("FAIL bp_head got v=%b nq=%b exp v=1 nq=1100", A_out_valid, A_nq); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (A_out_valid !== 1'b1 || A_nq !== 4'b1100 || A_occ !== 2'd2) $display("FAIL bp_hold got v=%b nq=%b occ=%0d exp v=1 nq=1100 occ=2", A_out_valid, A_nq, A_occ); else n_pass++;
    A_out_ready = 1;
    #1;
    n_total++; if (A_in_ready !== 1'b1) $display("FAIL bp_chain_ready got=%b exp=1", A_in_ready); else n_pass++;
    @(posedge ck); #1;
    A_in_valid = 0;
    n_total++; if (A_nq !== 4'b1011 || A_occ !== 2'd2) $display("FAIL bp_emit1 got nq=%b occ=%0d exp nq=1011 occ=2", A_nq, A_occ); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (A_nq !== 4'b0001 || A_occ !== 2'd1) $display("FAIL bp_emit2 got nq=%b occ=%0d exp nq=0001 occ=1", A_nq, A_occ); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (A_out_valid !== 1'b0 || A_busy !== 1'b0) $display("FAIL bp_empty got v=%b busy=%b exp 0/0", A_out_valid, A_busy); else n_pass++;
  endtask

  task automatic test_bubble;
    @(posedge ck); #1;
    B_out_ready = 0; B_in_valid = 1;
    B_mode = 0; B_i0 = 4'b0011; B_i1 = 4'b0110; B_i2 = 4'b1000;   // -> 0101
    @(posedge ck); #1;
    B_in_valid = 0;
    @(posedge ck); #1;
    n_total++; if (B_out_valid !== 1'b0) $display("FAIL bub_early got=%b exp=0", B_out_valid); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (B_out_valid !== 1'b1 || B_nq !== 4'b0101 || B_occ !== 2'd1) $display("FAIL bub_arrive got v=%b nq=%b occ=%0d exp v=1 nq=0101 occ=1", B_out_valid, B_nq, B_occ); else n_pass++;
    B_in_valid = 1; B_mode = 1; B_i0 = 4'b1000; B_i1 = 4'b0000; B_i2 = 4'b1111;   // -> 0111
    #1;
    n_total++; if (B_in_ready !== 1'b1) $display("FAIL bub_ready got=%b exp=1", B_in_ready); else n_pass++;
    @(posedge ck); #1;
    B_in_valid = 0;
    @(posedge ck); #1;
    n_total++; if (B_occ !== 2'd2 || B_nq !== 4'b0101 || B_out_valid !== 1'b1) $display("FAIL bub_collapse got occ=%0d nq=%b v=%b exp occ=2 nq=0101 v=1", B_occ, B_nq, B_out_valid); else n_pass++;
    B_out_ready = 1;
    @(posedge ck); #1;
    n_total++; if (B_nq !== 4'b0111 || B_occ !== 2'd1) $display("FAIL bub_second got nq=%b occ=%0d exp nq=0111 occ=1", B_nq, B_occ); else n_pass++;
    @(posedge ck); #1;
    n_total++; if (B_occ !== 2'd0 || B_busy !== 1'b0) $display("FAIL bub_empty got occ=%0d busy=%b exp 0/0", B_occ, B_busy); else n_pass++;
  endtask

  task automatic test_throughput;
    logic [7:0] q[$];
    logic [7:0] exp_v;
    int sent = 0, got = 0, first_e = -1, last_e = -1, rdy_low = 0;
    @(posedge ck); #1;
    C_out_ready = 1; C_in_valid = 1;
    C_mode = 1'($urandom); C_i0 = 8'($urandom); C_i1 = 8'($urandom); C_i2 = 8'($urandom);
    q.push_back(8'(aoi_eval(64'(C_i0), 64'(C_i1), 64'(C_i2), mode_t'(C_mode))));
    sent = 1;
    #1; if (C_in_ready !== 1'b1) rdy_low++;
    for (int e = 0; e < 110; e++) begin
      @(posedge ck); #1;
      if (C_out_valid === 1'b1) begin
        n_total++;
        if (q.size() == 0) $display("FAIL tp_spurious edge=%0d nq=%h exp no result", e, C_nq);
        else begin
          exp_v = q.pop_front();
          if (C_nq !== exp_v) $display("FAIL tp_result idx=%0d got=%h exp=%h", got, C_nq, exp_v); else n_pass++;
        end
        if (first_e < 0) first_e = e;
        last_e = e;
        got++;
      end
      if (sent < 100) begin
        C_mode = 1'($urandom); C_i0 = 8'($urandom); C_i1 = 8'($urandom); C_i2 = 8'($urandom);
        q.push_back(8'(aoi_eval(64'(C_i0), 64'(C_i1), 64'(C_i2), mode_t'(C_mode))));
        sent++;
        #1; if (C_in_ready !== 1'b1) rdy_low++;
      end else C_in_valid = 0;
    end
    n_total++; if (got !== 100) $display("FAIL tp_count got=%0d exp=100", got); else n_pass++;
    n_total++; if (first_e !== 3) $display("FAIL tp_latency got=%0d exp=3", first_e); else n_pass++;
    n_total++; if (last_e !== 102) $display("FAIL tp_last_edge got=%0d exp=102", last_e); else n_pass++;
    n_total++; if (rdy_low !== 0) $display("FAIL tp_in_ready_low got=%0d exp=0", rdy_low); else n_pass++;
    n_total++; if (C_busy !== 1'b0 || C_occ !== 3'd0) $display("FAIL tp_drain got busy=%b occ=%0d exp 0/0", C_busy, C_occ); else n_pass++;
  endtask

  task automatic test_truth_table;
    logic [15:0] tt;
    int q[$];
    int idx = 0, got = 0, cyc = 0, hold_bad = 0, exp_idx;
    logic prev_stall = 0, prev_nq = 0;
    tt = 16'h5715;   // bit {mode,i0,i1,i2} = expected nq
    @(posedge ck); #1;
    while (got < 16 && cyc < 400) begin
      if (prev_stall && (D_out_valid !== 1'b1 || D_nq[0] !== prev_nq)) hold_bad++;
      D_out_ready = 1'($urandom_range(0, 1));
      D_in_valid  = (idx < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      {D_mode, D_i0, D_i1, D_i2} = 4'(idx);
      #1;
      if (D_out_valid === 1'b1 && D_out_ready) begin
        n_total++;
        if (q.size() == 0) $display("FAIL tt_spurious nq=%b exp no result", D_nq);
        else begin
          exp_idx = q.pop_front();
          if (D_nq[0] !== tt[exp_idx]) $display("FAIL tt_entry idx=%0d got=%b exp=%b", exp_idx, D_nq, tt[exp_idx]); else n_pass++;
        end
        got++;
      end
      if (D_in_valid && D_in_ready === 1'b1) begin q.push_back(idx); idx++; end
      prev_stall = (D_out_valid === 1'b1) && !D_out_ready;
      prev_nq = D_nq[0];
      @(posedge ck); #1;
      cyc++;
    end
    D_in_valid = 0;
    n_total++; if (got !== 16) $display("FAIL tt_count got=%0d exp=16 (cycles=%0d)", got, cyc); else n_pass++;
    n_total++; if (hold_bad !== 0) $display("FAIL tt_hold got=%0d exp=0", hold_bad); else n_pass++;
    n_total++; if (q.size() !== 0 || D_busy !== 1'b0 || D_occ !== 2'd0) $display("FAIL tt_leftover got q=%0d busy=%b occ=%0d exp 0/0/0", q.size(), D_busy, D_occ); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_aoi_oai();
    test_backpressure();
    test_bubble();
    test_throughput();
    test_truth_table();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
